// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: control-bundle layout, the hard-wired
// zero register and the bubble encoding loaded into pipeline registers.
package mips_pkg;

    // Width of the packed control bundle carried down the pipeline.
    localparam int CTRL_W = 16;

    // Bit offsets of the control fields inside the bundle.
    localparam int CTRL_REGWRITE  = 0;
    localparam int CTRL_MEMTOREG  = 1;
    localparam int CTRL_MEMWRITE  = 2;
    localparam int CTRL_ALUSRC    = 3;
    localparam int CTRL_REGDST    = 4;
    localparam int CTRL_ALUCTRL   = 5;
    localparam int CTRL_ALUCTRL_W = 3;

    // Register $0 always reads as zero.
    localparam int unsigned REG_ZERO = 0;

    // A bubble is an instruction whose control bundle is all zero: it
    // writes nothing and touches no memory.
    localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

endpackage

// File: rtl/operand_bypass.sv
// Operand select for one E-stage source operand.
// With FORWARD_WB_EN defined, a matching write-back replaces the supplied
// operand; the zero register always forces the result to zero.
module operand_bypass
    import mips_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int AW    = 5
) (
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] rf_data,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic [WIDTH-1:0] wd,
    output logic [WIDTH-1:0] data
);

`ifndef FORWARD_WB_EN
    // Write-back port is only consulted when forwarding is built in.
    logic unused_wb;
    assign unused_wb = ^{we, wa, wd};
`endif

    // Pick write-back data on an address match, then apply the $0 override.
    always_comb begin
        // NOTE: assigning the default first keeps every path driven, so no latch is inferred.
        data = rf_data;
`ifdef FORWARD_WB_EN
        if (we && (wa == addr)) begin
            data = wd;
        end
`endif
        if (addr == AW'(REG_ZERO)) begin
            data = '0;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register with stall, flush and a saturating
// bubble counter. Defining FORWARD_WB_EN bypasses same-cycle write-back
// data into operands being loaded and into operands held by a stall.
module id_ex_stage #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 32,
    parameter int CTRL_W = mips_pkg::CTRL_W,
    parameter int CNT_W  = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              VALID_D,
    input  logic              STALL_E,
    input  logic              FLUSH_E,
    input  logic [AW-1:0]     RS_D,
    input  logic [AW-1:0]     RT_D,
    input  logic [AW-1:0]     RD_D,
    input  logic [WIDTH-1:0]  RD1_D,
    input  logic [WIDTH-1:0]  RD2_D,
    input  logic [WIDTH-1:0]  IMM_D,
    input  logic [CTRL_W-1:0] CTRL_D,
    input  logic              WE3_W,
    input  logic [AW-1:0]     A3_W,
    input  logic [WIDTH-1:0]  WD3_W,
    output logic              VALID_E,
    output logic [AW-1:0]     RS_E,
    output logic [AW-1:0]     RT_E,
    output logic [AW-1:0]     RD_E,
    output logic [WIDTH-1:0]  SRCA_E,
    output logic [WIDTH-1:0]  SRCB_E,
    output logic [WIDTH-1:0]  IMM_E,
    output logic [CTRL_W-1:0] CTRL_E,
    output logic [CNT_W-1:0]  BUBBLE_CNT
);

    import mips_pkg::*;

    logic             load_bubble;
    logic [AW-1:0]    sel_rs;
    logic [AW-1:0]    sel_rt;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic             bp_we;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;

    // A flush, or an empty decode slot that is not stalled, loads a bubble.
    assign load_bubble = FLUSH_E || (!STALL_E && !VALID_D);

    // On a stall the bypass looks at the held operand and its address, so
    // the same two muxes serve both load-time forwarding and stall refresh.
    // A held bubble must never be refreshed, hence the VALID_E gate.
    assign sel_rs = STALL_E ? RS_E   : RS_D;
    assign sel_rt = STALL_E ? RT_E   : RT_D;
    assign sel_a  = STALL_E ? SRCA_E : RD1_D;
    assign sel_b  = STALL_E ? SRCB_E : RD2_D;
    assign bp_we  = WE3_W && (STALL_E ? VALID_E : 1'b1);

    operand_bypass #(.WIDTH(WIDTH), .AW(AW)) u_bypass_a (
        .addr    (sel_rs),
        .rf_data (sel_a),
        .we      (bp_we),
        .wa      (A3_W),
        .wd      (WD3_W),
        .data    (op_a)
    );

    operand_bypass #(.WIDTH(WIDTH), .AW(AW)) u_bypass_b (
        .addr    (sel_rt),
        .rf_data (sel_b),
        .we      (bp_we),
        .wa      (A3_W),
        .wd      (WD3_W),
        .data    (op_b)
    );

    // Pipeline register: reset > flush/bubble > stall > load.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            VALID_E    <= 1'b0;
            RS_E       <= '0;
            RT_E       <= '0;
            RD_E       <= '0;
            SRCA_E     <= '0;
            SRCB_E     <= '0;
            IMM_E      <= '0;
            CTRL_E     <= '0;
            BUBBLE_CNT <= '0;
        end else if (load_bubble) begin
            // NOTE: non-blocking assignments so every field updates from pre-edge values.
            VALID_E <= 1'b0;
            RS_E    <= '0;
            RT_E    <= '0;
            RD_E    <= '0;
            SRCA_E  <= '0;
            SRCB_E  <= '0;
            IMM_E   <= '0;
            CTRL_E  <= CTRL_W'(CTRL_BUBBLE);
            if (BUBBLE_CNT != {CNT_W{1'b1}}) begin
                BUBBLE_CNT <= BUBBLE_CNT + CNT_W'(1);
            end
        end else if (STALL_E) begin
            // Everything else holds; operands pass through the bypass, which
            // returns the held value unless a refresh applies.
            SRCA_E <= op_a;
            SRCB_E <= op_b;
        end else begin
            VALID_E <= 1'b1;
            RS_E    <= RS_D;
            RT_E    <= RT_D;
            RD_E    <= RD_D;
            SRCA_E  <= op_a;
            SRCB_E  <= op_b;
            IMM_E   <= IMM_D;
            CTRL_E  <= CTRL_D;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus random
// traffic, each cycle's expected E-stage contents queued by the driver and
// compared by an independent monitor on the falling edge.
module tb_id_ex_stage;

    localparam int WIDTH  = 32;
    localparam int DEPTH  = 32;
    localparam int AW     = 5;
    localparam int CTRL_W = 16;
    localparam int CNT_W  = 4;

`ifdef FORWARD_WB_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic              CLK = 1'b0;
    logic              RST_N;
    logic              VALID_D, STALL_E, FLUSH_E;
    logic [AW-1:0]     RS_D, RT_D, RD_D;
    logic [WIDTH-1:0]  RD1_D, RD2_D, IMM_D;
    logic [CTRL_W-1:0] CTRL_D;
    logic              WE3_W;
    logic [AW-1:0]     A3_W;
    logic [WIDTH-1:0]  WD3_W;
    logic              VALID_E;
    logic [AW-1:0]     RS_E, RT_E, RD_E;
    logic [WIDTH-1:0]  SRCA_E, SRCB_E, IMM_E;
    logic [CTRL_W-1:0] CTRL_E;
    logic [CNT_W-1:0]  BUBBLE_CNT;

    id_ex_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST_N(RST_N), .VALID_D(VALID_D), .STALL_E(STALL_E), .FLUSH_E(FLUSH_E),
        .RS_D(RS_D), .RT_D(RT_D), .RD_D(RD_D), .RD1_D(RD1_D), .RD2_D(RD2_D),
        .IMM_D(IMM_D), .CTRL_D(CTRL_D), .WE3_W(WE3_W), .A3_W(A3_W), .WD3_W(WD3_W),
        .VALID_E(VALID_E), .RS_E(RS_E), .RT_E(RT_E), .RD_E(RD_E),
        .SRCA_E(SRCA_E), .SRCB_E(SRCB_E), .IMM_E(IMM_E), .CTRL_E(CTRL_E),
        .BUBBLE_CNT(BUBBLE_CNT)
    );

    always #10 CLK = ~CLK;

    typedef struct {
        logic              valid;
        logic [AW-1:0]     rs, rt, rd;
        logic [WIDTH-1:0]  srca, srcb, imm;
        logic [CTRL_W-1:0] ctrl;
        logic [CNT_W-1:0]  cnt;
    } e_t;

    e_t model;
    e_t exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic e_t empty_e();
        e_t z;
        z.valid = 1'b0; z.rs = '0; z.rt = '0; z.rd = '0;
        z.srca = '0; z.srcb = '0; z.imm = '0; z.ctrl = '0; z.cnt = '0;
        return z;
    endfunction

    // Reference behaviour: what the E stage should hold after the coming
    // edge, given its current contents and the inputs now applied.
    function automatic e_t model_next(input e_t s);
        e_t n;
        n = s;
        if (FLUSH_E || (!STALL_E && !VALID_D)) begin
            n = empty_e();
            n.cnt = (s.cnt == {CNT_W{1'b1}}) ? s.cnt : s.cnt + 1'b1;
        end else if (STALL_E) begin
            if (FWD && s.valid && WE3_W && A3_W != 0 && A3_W == s.rs) n.srca = WD3_W;
            if (FWD && s.valid && WE3_W && A3_W != 0 && A3_W == s.rt) n.srcb = WD3_W;
        end else begin
            n.valid = 1'b1;
            n.rs = RS_D; n.rt = RT_D; n.rd = RD_D;
            n.imm = IMM_D; n.ctrl = CTRL_D;
            if (RS_D == 0)                          n.srca = '0;
            else if (FWD && WE3_W && A3_W == RS_D)  n.srca = WD3_W;
            else                                    n.srca = RD1_D;
            if (RT_D == 0)                          n.srcb = '0;
            else if (FWD && WE3_W && A3_W == RT_D)  n.srcb = WD3_W;
            else                                    n.srcb = RD2_D;
        end
        return n;
    endfunction

    // Apply one cycle of inputs, queue the expectation, wait past the edge.
    task automatic step(input logic vd, input logic st, input logic fl,
                        input logic [AW-1:0] rs, input logic [AW-1:0] rt, input logic [AW-1:0] rd,
                        input logic [WIDTH-1:0] rd1, input logic [WIDTH-1:0] rd2,
                        input logic [WIDTH-1:0] imm, input logic [CTRL_W-1:0] ctrl,
                        input logic we, input logic [AW-1:0] a3, input logic [WIDTH-1:0] wd);
        VALID_D = vd; STALL_E = st; FLUSH_E = fl;
        RS_D = rs; RT_D = rt; RD_D = rd;
        RD1_D = rd1; RD2_D = rd2; IMM_D = imm; CTRL_D = ctrl;
        WE3_W = we; A3_W = a3; WD3_W = wd;
        model = model_next(model);
        exp_q.push_back(model);
        @(negedge CLK);
        #1;
    endtask

    // Asynchronous reset pulse inside the low phase, away from any edge.
    task automatic mid_cycle_reset();
        #2;
        RST_N = 1'b0;
        #1;
        check("rst_valid", 64'(VALID_E), 64'(0));
        check("rst_srca",  64'(SRCA_E),  64'(0));
        check("rst_srcb",  64'(SRCB_E),  64'(0));
        check("rst_imm",   64'(IMM_E),   64'(0));
        check("rst_ctrl",  64'(CTRL_E),  64'(0));
        check("rst_addr",  64'({RS_E, RT_E, RD_E}), 64'(0));
        check("rst_cnt",   64'(BUBBLE_CNT), 64'(0));
        model = empty_e();
        #1;
        RST_N = 1'b1;
    endtask

    // Monitor: every falling edge, compare the E stage with the oldest expectation.
    always @(negedge CLK) begin
        e_t e;
        if (RST_N && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("valid_e", 64'(VALID_E), 64'(e.valid));
            check("rs_e",    64'(RS_E),    64'(e.rs));
            check("rt_e",    64'(RT_E),    64'(e.rt));
            check("rd_e",    64'(RD_E),    64'(e.rd));
            check("srca_e",  64'(SRCA_E),  64'(e.srca));
            check("srcb_e",  64'(SRCB_E),  64'(e.srcb));
            check("imm_e",   64'(IMM_E),   64'(e.imm));
            check("ctrl_e",  64'(CTRL_E),  64'(e.ctrl));
            check("bubble_cnt", 64'(BUBBLE_CNT), 64'(e.cnt));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic vd, st, fl, we;
        logic [AW-1:0] rs, rt, rd, a3;
        logic [WIDTH-1:0] rd1, rd2, imm, wd;
        logic [CTRL_W-1:0] ctrl;

        model = empty_e();
        RST_N = 1'b0;
        VALID_D = 0; STALL_E = 0; FLUSH_E = 0;
        RS_D = '0; RT_D = '0; RD_D = '0; RD1_D = '0; RD2_D = '0; IMM_D = '0; CTRL_D = '0;
        WE3_W = 0; A3_W = '0; WD3_W = '0;
        #5;
        check("init_rst_valid", 64'(VALID_E), 64'(0));
        check("init_rst_cnt",   64'(BUBBLE_CNT), 64'(0));
        @(negedge CLK);
        #1;
        RST_N = 1'b1;

        // Plain load.
        step(1, 0, 0, 5'd3, 5'd4, 5'd6, 32'h1234, 32'h5678, 32'hFFFF_FFF0, 16'h00A5, 0, 5'd0, 32'h0);
        check("plain_srca",  64'(SRCA_E), 64'(32'h1234));
        check("plain_imm",   64'(IMM_E),  64'(32'hFFFF_FFF0));
        check("plain_ctrl",  64'(CTRL_E), 64'(16'h00A5));
        check("plain_valid", 64'(VALID_E), 64'(1));

        // Asynchronous reset while VALID_E is high.
        check("pre_rst_valid", 64'(VALID_E), 64'(1));
        mid_cycle_reset();

        // Load, stall three cycles with changing D-side inputs, then flush+stall.
        step(1, 0, 0, 5'd3, 5'd4, 5'd6, 32'hAAAA, 32'hBBBB, 32'h10, 16'h0033, 0, 5'd0, 32'h0);
        for (int i = 0; i < 3; i++)
            step(1, 1, 0, 5'd9, 5'd10, 5'd11, 32'hDEAD, 32'hBEEF, 32'h77, 16'h1111, 0, 5'd0, 32'h0);
        check("stall_srca", 64'(SRCA_E), 64'(32'hAAAA));
        check("stall_ctrl", 64'(CTRL_E), 64'(16'h0033));
        step(1, 1, 1, 5'd9, 5'd10, 5'd11, 32'hDEAD, 32'hBEEF, 32'h77, 16'h1111, 0, 5'd0, 32'h0);
        check("flush_valid", 64'(VALID_E), 64'(0));
        check("flush_ctrl",  64'(CTRL_E),  64'(0));
        check("flush_cnt",   64'(BUBBLE_CNT), 64'(1));

        // Write-back collision on load.
        step(1, 0, 0, 5'd5, 5'd6, 5'd7, 32'h11, 32'h22, 32'h0, 16'h0001, 1, 5'd5, 32'h99);
        check("bypass_load_srca", 64'(SRCA_E), FWD ? 64'(32'h99) : 64'(32'h11));

        // Operand refresh during stall.
        step(1, 0, 0, 5'd8, 5'd7, 5'd2, 32'h3, 32'h1, 32'h0, 16'h0002, 0, 5'd0, 32'h0);
        step(1, 1, 0, 5'd1, 5'd1, 5'd1, 32'h0, 32'h0, 32'h0, 16'h0000, 1, 5'd7, 32'hBEEF);
        check("refresh_srcb", 64'(SRCB_E), FWD ? 64'(32'hBEEF) : 64'(32'h1));
        check("refresh_srca", 64'(SRCA_E), 64'(32'h3));

        // Zero register wins over read data and bypass.
        step(1, 0, 0, 5'd0, 5'd0, 5'd4, 32'hDEAD, 32'hCAFE, 32'h0, 16'h0004, 1, 5'd0, 32'h55);
        check("zero_srca", 64'(SRCA_E), 64'(0));
        check("zero_srcb", 64'(SRCB_E), 64'(0));

        // Twenty consecutive bubbles saturate the 4-bit counter.
        for (int i = 0; i < 20; i++)
            step(0, 0, 0, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h3, 16'h0005, 0, 5'd0, 32'h0);
        check("sat_cnt", 64'(BUBBLE_CNT), 64'(4'hF));

        // Random traffic with narrow address range to provoke collisions.
        mid_cycle_reset();
        for (int i = 0; i < 400; i++) begin
            vd   = ($urandom_range(0, 9) < 8);
            st   = ($urandom_range(0, 3) == 0);
            fl   = ($urandom_range(0, 15) == 0);
            rs   = AW'($urandom_range(0, 7));
            rt   = AW'($urandom_range(0, 7));
            rd   = AW'($urandom_range(0, 31));
            rd1  = $urandom;
            rd2  = $urandom;
            imm  = $urandom;
            ctrl = CTRL_W'($urandom);
            we   = $urandom_range(0, 1) == 1;
            a3   = AW'($urandom_range(0, 7));
            wd   = $urandom;
            step(vd, st, fl, rs, rt, rd, rd1, rd2, imm, ctrl, we, a3, wd);
        end

        @(negedge CLK);
        #1;
        check("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
